input_capture_sequencer: RTL and testbench
==========================================

// Module: input_capture_sequencer
// PURPOSE
//  Sequences a WIDTH-bit bank of ECP5 input registers of the SP/SCLK/CD kind (clock enable, async clear).
//  Clears the bank, then issues single-cycle SP strobes at a programmable cadence.
//  Returns each captured word over a valid/ready interface.
//  Sits between the pad-side input register bank and the fabric consumer.
//  Supports fixed-length bursts and continuous sampling.
// PARAMETERS
//  WIDTH      8  number of input register bits in the bank (Q_IN/DOUT width)
//  DIV_W      8  width of the sample-period divider
//  CNT_W      8  width of the burst sample counter
//  CLR_CYCLES 2  cycles CD is held high in CLEAR (>=1)
// PORTS
//  SCLK     in   1      single clock; the bank and this block share it
//  RSTN     in   1      asynchronous, active-low reset
//  START    in   1      one-cycle pulse; begins a burst; ignored unless IDLE
//  STOP     in   1      level/pulse; aborts sampling at next edge
//  DIV      in   DIV_W  sample period minus 1; latched at START
//  COUNT    in   CNT_W  samples per burst, 0 = continuous; latched at START
//  SP       out  1      clock enable to the input register bank
//  CD       out  1      clear to the input register bank, active-high
//  Q_IN     in   WIDTH  Q outputs of the input register bank
//  DOUT     out  WIDTH  captured word
//  DVALID   out  1      DOUT valid; held until DREADY
//  DREADY   in   1      consumer accepts DOUT when DVALID&DREADY at an edge
//  BUSY     out  1      FSM not in IDLE
//  OVERRUN  out  1      sticky; a sample was dropped; cleared by accepted START
// BEHAVIOUR
//  Reset (RSTN=0, async):
//   - FSM=IDLE; SP=0; CD=1; DOUT=0; DVALID=0; BUSY=0; OVERRUN=0.
//   - CD drops to 0 at the first edge after RSTN deasserts.
//  All outputs are registered.
//  FSM states IDLE, CLEAR, RUN:
//   - IDLE -> CLEAR on START&!STOP:
//     latch DIV/COUNT, clear OVERRUN, load clear counter.
//   - CLEAR: CD=1 for exactly CLR_CYCLES cycles, then -> RUN with period counter=0.
//   - RUN: period counter counts 0..DIV.
//     SP=1 in the cycle the counter equals 0, i.e. first SP in first RUN cycle,
//     then every DIV+1 cycles; DIV=0 gives SP every cycle.
//   - RUN, COUNT!=0: after the COUNT-th SP cycle -> IDLE (no further SP).
//   - RUN, COUNT==0: continues until STOP.
//   - STOP in CLEAR or RUN: -> IDLE at next edge; SP/CD deassert there.
//   - STOP wins over START in the same cycle.
//  Capture pipeline (independent of FSM state):
//   - SP high in cycle n: bank captures D at end of n; Q_IN valid in n+1.
//   - This block registers Q_IN at end of n+1: DOUT/DVALID visible in n+2.
//   - Latency SP->DVALID is 2 cycles.
//   - Samples in flight at STOP or burst end still complete.
//  Output register, single entry:
//   - Capture while DVALID=1 and DREADY=0: new word dropped, DOUT unchanged, OVERRUN<=1.
//   - Capture with DVALID&DREADY in the same cycle: new word loads, no overrun.
//   - No capture and DVALID&DREADY: DVALID<=0.
//  BUSY=1 in CLEAR and RUN. A START while BUSY is ignored.
//  RSTN asserted mid-burst: immediate return to reset values; the pending word is lost.
// TESTING
//  T1 reset: RSTN=0 mid-RUN -> SP=0, CD=1, DVALID=0 at once; CD=0 one edge after release.
//  T2 DIV=3, COUNT=4, DREADY=1, START at c0:
//     CD=1 c1-c2; SP at c3,c7,c11,c15; DVALID c5,c9,c13,c17; BUSY low from c16.
//  T3 DIV=0, COUNT=0, DREADY=1: SP every cycle; STOP at c20 -> last SP c20,
//     two trailing words delivered, BUSY=0 at c21.
//  T4 DIV=1, COUNT=3, DREADY=0: first word held;
//     words 2,3 dropped, OVERRUN=1; DOUT equals first Q_IN value.
//  T5 START and STOP same cycle -> stays IDLE.
//     START during RUN -> ignored; DIV/COUNT not relatched.
//  T6 Q_IN driven with a counter pattern -> each DOUT equals Q_IN one cycle after its SP.

Source files
------------

// File: rtl/input_capture_sequencer.sv
// rtl/input_capture_sequencer.sv - clear/strobe sequencer and single-entry capture register for an input register bank
module input_capture_sequencer #(
    parameter int WIDTH      = 8,
    parameter int DIV_W      = 8,
    parameter int CNT_W      = 8,
    parameter int CLR_CYCLES = 2
) (
    input  logic             sclk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] count,
    output logic             sp,
    output logic             cd,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    input  logic             dready,
    output logic             busy,
    output logic             overrun
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_l;
    logic [CNT_W-1:0] count_l;
    logic [DIV_W-1:0] pcnt;
    logic [CNT_W-1:0] scnt;
    logic [CLR_W-1:0] ccnt;
    logic             sp_d1;
    logic             start_acc;
    logic             burst_done;

    // A START only counts in IDLE and only if STOP is not also present
    assign start_acc  = (state == IDLE) && start && !stop;
    // The strobe being issued this cycle is the last of a fixed-length burst
    assign burst_done = sp && (count_l != '0) && ((scnt + CNT_W'(1)) == count_l);

    // Sequencer FSM: outputs sp/cd/busy are registered alongside the state
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            sp      <= 1'b0;
            cd      <= 1'b1;
            busy    <= 1'b0;
            div_l   <= '0;
            count_l <= '0;
            pcnt    <= '0;
            scnt    <= '0;
            ccnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sp <= 1'b0;
                    cd <= 1'b0;
                    if (start_acc) begin
                        state   <= CLEAR;
                        div_l   <= div;
                        count_l <= count;
                        ccnt    <= CLR_LOAD;
                        scnt    <= '0;
                        cd      <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (stop) begin
                        state <= IDLE;
                        cd    <= 1'b0;
                        sp    <= 1'b0;
                        busy  <= 1'b0;
                    end else if (ccnt == '0) begin
                        // first strobe lands in the first RUN cycle
                        state <= RUN;
                        cd    <= 1'b0;
                        pcnt  <= '0;
                        sp    <= 1'b1;
                    end else begin
                        ccnt <= ccnt - CLR_W'(1);
                    end
                end
                RUN: begin
                    if (stop || burst_done) begin
                        state <= IDLE;
                        sp    <= 1'b0;
                        busy  <= 1'b0;
                    end else begin
                        // strobe is raised for the cycle in which the counter wraps to 0
                        if (pcnt == div_l) begin
                            pcnt <= '0;
                            sp   <= 1'b1;
                        end else begin
                            pcnt <= pcnt + DIV_W'(1);
                            sp   <= 1'b0;
                        end
                        if (sp) begin
                            scnt <= scnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sp    <= 1'b0;
                    cd    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tracks which cycle has fresh bank data: one cycle after each strobe
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            sp_d1 <= 1'b0;
        end else begin
            sp_d1 <= sp;
        end
    end

    // Single-entry output register; a word arriving while the held one is unaccepted is dropped
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            dout    <= '0;
            dvalid  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (start_acc) begin
                overrun <= 1'b0;
            end
            if (sp_d1) begin
                if (!dvalid || dready) begin
                    dout   <= q_in;
                    dvalid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dvalid && dready) begin
                dvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_input_capture_sequencer.sv
// tb/tb_input_capture_sequencer.sv - directed bench for input_capture_sequencer
module tb_input_capture_sequencer;

    logic       sclk = 1'b0;
    logic       rstn;
    logic       start;
    logic       stop;
    logic [7:0] div;
    logic [7:0] count;
    logic       sp;
    logic       cd;
    logic [7:0] q_in;
    logic [7:0] dout;
    logic       dvalid;
    logic       dready;
    logic       busy;
    logic       overrun;
    logic [7:0] d;
    logic [7:0] bank;

    int checks = 0;
    int errors = 0;

    input_capture_sequencer #(
        .WIDTH(8), .DIV_W(8), .CNT_W(8), .CLR_CYCLES(2)
    ) dut (
        .sclk(sclk), .rstn(rstn), .start(start), .stop(stop),
        .div(div), .count(count), .sp(sp), .cd(cd), .q_in(q_in),
        .dout(dout), .dvalid(dvalid), .dready(dready),
        .busy(busy), .overrun(overrun)
    );

    always #5 sclk = ~sclk;

    // Behavioural input register bank: clear on cd, capture d on sp
    always @(posedge sclk) begin
        if (cd) bank <= 8'h00;
        else if (sp) bank <= d;
    end
    assign q_in = bank;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; stop = 1'b0; div = 8'd0; count = 8'd0;
        dready = 1'b0; d = 8'h00;
        step(); step();
        check("rst_sp", sp, 0);
        check("rst_cd", cd, 1);
        check("rst_dvalid", dvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_dout", dout, 0);
        rstn = 1'b1;
        step();
        check("rst_cd_release", cd, 0);
        step(); step();

        // T2 + T6: DIV=3 COUNT=4, counter pattern on d
        div = 8'd3; count = 8'd4; dready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            start = (c == 0);
            d = 8'hA0 + 8'(c);
            check($sformatf("t2_sp_c%0d", c), sp, (c >= 3 && c <= 15 && (c % 4) == 3));
            check($sformatf("t2_cd_c%0d", c), cd, (c == 1 || c == 2));
            check($sformatf("t2_dvalid_c%0d", c), dvalid, (c >= 5 && c <= 17 && (c % 4) == 1));
            check($sformatf("t2_busy_c%0d", c), busy, (c >= 1 && c <= 15));
            if (c >= 5 && c <= 17 && (c % 4) == 1)
                check($sformatf("t2_dout_c%0d", c), dout, 8'hA0 + 8'(c - 2));
            step();
        end
        start = 1'b0;
        step();

        // T3: DIV=0 continuous, STOP at c20
        div = 8'd0; count = 8'd0; dready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            start = (c == 0);
            stop  = (c == 20);
            d = 8'h30 + 8'(c);
            check($sformatf("t3_sp_c%0d", c), sp, (c >= 3 && c <= 20));
            check($sformatf("t3_busy_c%0d", c), busy, (c >= 1 && c <= 20));
            check($sformatf("t3_dvalid_c%0d", c), dvalid, (c >= 5 && c <= 22));
            if (c >= 5 && c <= 22)
                check($sformatf("t3_dout_c%0d", c), dout, 8'h30 + 8'(c - 2));
            step();
        end
        start = 1'b0; stop = 1'b0;

        // T4: DIV=1 COUNT=3, consumer stalled
        div = 8'd1; count = 8'd3; dready = 1'b0;
        for (int c = 0; c < 13; c++) begin
            start = (c == 0);
            d = 8'h50 + 8'(c);
            check($sformatf("t4_sp_c%0d", c), sp, (c == 3 || c == 5 || c == 7));
            if (c == 6) check("t4_overrun_c6", overrun, 0);
            if (c >= 7) check($sformatf("t4_overrun_c%0d", c), overrun, 1);
            if (c >= 5) begin
                check($sformatf("t4_dvalid_c%0d", c), dvalid, 1);
                check($sformatf("t4_dout_c%0d", c), dout, 8'h53);
            end
            if (c >= 8) check($sformatf("t4_busy_c%0d", c), busy, 0);
            step();
        end
        start = 1'b0;
        dready = 1'b1;
        step();
        check("t4_drain", dvalid, 0);

        // T5a: START and STOP together stay IDLE, overrun untouched
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t5_both_busy", busy, 0);
        check("t5_both_cd", cd, 0);
        step();
        check("t5_both_busy2", busy, 0);
        check("t5_both_overrun", overrun, 1);

        // T5b: START mid-RUN ignored, DIV/COUNT not relatched
        div = 8'd1; count = 8'd0;
        for (int c = 0; c < 16; c++) begin
            start = (c == 0 || c == 6);
            if (c == 6) begin div = 8'd5; count = 8'd2; end
            stop = (c == 14);
            if (c == 1) check("t5_overrun_clr", overrun, 0);
            if (c >= 3 && c <= 14)
                check($sformatf("t5_sp_c%0d", c), sp, (c % 2) == 1);
            check($sformatf("t5_busy_c%0d", c), busy, (c >= 1 && c <= 14));
            step();
        end
        start = 1'b0; stop = 1'b0;

        // T1: async reset mid-RUN with a held word
        div = 8'd0; count = 8'd0; dready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 6; c++) step();
        check("t1_pre_dvalid", dvalid, 1);
        check("t1_pre_busy", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check("t1_sp", sp, 0);
        check("t1_cd", cd, 1);
        check("t1_dvalid", dvalid, 0);
        check("t1_busy", busy, 0);
        step();
        rstn = 1'b1;
        check("t1_cd_held", cd, 1);
        step();
        check("t1_cd_release", cd, 0);
        check("t1_sp_after", sp, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
